// File: rtl/b2s_transmitter.sv
// b2s link transmitter: sends a WIDTH-bit word as pulse-width-coded low pulses,
// a long start pulse first, then one pulse per bit, LSB first.
module b2s_transmitter #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned START_LOW = 240,
  parameter int unsigned ONE_LOW   = 16,
  parameter int unsigned ZERO_LOW  = 96,
  parameter int unsigned HIGH_TIME = 16,
  parameter int unsigned GAP_TIME  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             b2s_dout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Phase counter is loaded with (length - 1) and the phase ends when it reads zero.
  localparam logic [7:0] StartLd = 8'(START_LOW - 1);
  localparam logic [7:0] OneLd   = 8'(ONE_LOW - 1);
  localparam logic [7:0] ZeroLd  = 8'(ZERO_LOW - 1);
  localparam logic [7:0] HighLd  = 8'(HIGH_TIME - 1);
  localparam logic [7:0] GapLd   = 8'(GAP_TIME - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStartLo,
    StStartHi,
    StBitLo,
    StBitHi,
    StGap
  } state_e;

  state_e           state_q;
  logic [7:0]       phase_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [WIDTH-1:0] shift_q;

  logic [7:0] bit_low_ld;
  logic       phase_end;

  always_comb begin
    bit_low_ld = shift_q[0] ? OneLd : ZeroLd;
    phase_end  = (phase_q == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      phase_q   <= 8'd0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      b2s_dout  <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          b2s_dout <= 1'b1;
          if (start) begin
            shift_q   <= din;
            bit_cnt_q <= CntW'(WIDTH);
            phase_q   <= StartLd;
            b2s_dout  <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StStartLo;
          end
        end

        StStartLo: begin
          if (phase_end) begin
            b2s_dout <= 1'b1;
            phase_q  <= HighLd;
            state_q  <= StStartHi;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        StStartHi: begin
          if (phase_end) begin
            b2s_dout <= 1'b0;
            phase_q  <= bit_low_ld;
            state_q  <= StBitLo;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        StBitLo: begin
          if (phase_end) begin
            b2s_dout  <= 1'b1;
            phase_q   <= HighLd;
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q - CntW'(1);
            state_q   <= StBitHi;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        StBitHi: begin
          if (phase_end) begin
            // shift_q already holds the next bit in position 0.
            if (bit_cnt_q != '0) begin
              b2s_dout <= 1'b0;
              phase_q  <= bit_low_ld;
              state_q  <= StBitLo;
            end else begin
              phase_q <= GapLd;
              state_q <= StGap;
            end
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        StGap: begin
          if (phase_end) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        default: begin
          state_q  <= StIdle;
          busy     <= 1'b0;
          b2s_dout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/b2s_transmitter.md
Name: b2s_transmitter

Overview:
Serialises a WIDTH-bit parallel word onto the single-wire b2s link as pulse-width-coded low pulses. The frame is a long start pulse followed by one pulse per data bit, LSB first. It sits at the far end of the link from the b2s receiver, which decodes each frame by measuring how long the line stays low. Both ends run from clocks of identical frequency; each low duration below is counted in clk cycles.

Parameters:
WIDTH, 64, data bits per frame; must match the receiver's WIDTH
START_LOW, 240, low cycles of the start pulse; receiver accepts 231..249
ONE_LOW, 16, low cycles encoding a 1; receiver accepts 11..24
ZERO_LOW, 96, low cycles encoding a 0; receiver accepts 51..144
HIGH_TIME, 16, high cycles after every low pulse (start and bits); minimum 4
GAP_TIME, 32, additional idle-high cycles after the last bit before the next frame may start; minimum 1

Ports:
clk  input  1  system clock, same frequency as receiver clk
rst_n  input  1  synchronous reset, active-low
din  input  WIDTH  word to transmit; sampled only when a start is accepted
start  input  1  request to send din; accepted only when busy=0
busy  output  1  high from the cycle after acceptance until the frame (including gap) ends
done  output  1  one-cycle pulse at frame completion
b2s_dout  output  1  serial line, idles high, driven from a register

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low. All outputs are registered.
- Reset values: b2s_dout=1, busy=0, done=0, state=IDLE, counters=0. Reset mid-frame aborts the frame. The line is high at the next edge and no done pulse is issued.
- Counters: an 8-bit phase counter (all timing parameters are 1..255) and a bit counter of width clog2(WIDTH+1).
- State machine: IDLE, START_LO, START_HI, BIT_LO, BIT_HI, GAP.
- IDLE: b2s_dout=1. If start=1 at edge T, then at edge T+1:
  - shift register <= din; bit counter <= WIDTH
  - b2s_dout <= 0; busy <= 1; state <= START_LO
- START_LO: line low for exactly START_LOW cycles, then b2s_dout <= 1 and state <= START_HI.
- START_HI: high for HIGH_TIME cycles, then:
  - b2s_dout <= 0; state <= BIT_LO
  - low length = ONE_LOW if shift[0]=1, else ZERO_LOW
- BIT_LO: low for the selected length, then:
  - b2s_dout <= 1; state <= BIT_HI
  - shift register >> 1; bit counter - 1
- BIT_HI: high for HIGH_TIME cycles. Then:
  - if bit counter != 0: next BIT_LO pulse, as above
  - else: state <= GAP
- GAP: high for GAP_TIME cycles, then busy <= 0, done <= 1 for one cycle, state <= IDLE.
- Bit order: din[0] is sent first and din[WIDTH-1] last. This lands din[k] in receiver dout[k].
- Frame length in cycles from the first low edge to busy falling: START_LOW + HIGH_TIME + n1*(ONE_LOW+HIGH_TIME) + n0*(ZERO_LOW+HIGH_TIME) + GAP_TIME, where n1 is the count of ones and n0 the count of zeros in din.
- start while busy=1 is ignored; din changes during a frame have no effect.
- In the done cycle busy=0, so a start in that cycle is accepted. This gives back-to-back frames with no extra idle beyond GAP_TIME.
- Pulse widths are exact (±0 cycles). No glitches on b2s_dout within a phase.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> b2s_dout=1, busy=0, done=0 throughout; no frame starts until rst_n=1.
- WIDTH=8, din=8'hA5, one start pulse:
  - low widths 240,16,96,16,96,96,16,96,16 (start, then 1,0,1,0,0,1,0,1)
  - each followed by 16 high cycles
  - busy high for 864 cycles, then one done pulse
- All-zeros and all-ones, WIDTH=64 -> 64 low pulses of 96 (respectively 16) cycles each; the connected b2s receiver reports dout=0 (respectively all ones) with finish=1.
- start held high continuously, din changed each frame (8'h01 then 8'h80) -> second frame begins the cycle after done with no gap beyond GAP_TIME; receiver decodes 8'h01 then 8'h80; mid-frame din changes are ignored.
- start asserted while busy -> ignored; frame content and length unchanged; exactly one done per accepted start.
- rst_n pulsed low during BIT_LO of bit 3 -> line high next cycle, busy=0, no done. A subsequent start sends a complete fresh frame that the receiver decodes correctly.
